// File: rtl/tempsense_result_tx_pkg.sv
// Shared constants for the temperature-result UART transmitter: TX state encoding,
// byte markers and 8N1 frame constants.
package tempsense_result_tx_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Bit 7 of each packet byte tells the logger which half of the packet it is.
  localparam logic MarkA = 1'b1;
  localparam logic MarkB = 1'b0;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;
  localparam int unsigned DataBits = 8;

  function automatic logic [7:0] pack_byte(input logic mark, input logic [6:0] payload);
    return {mark, payload};
  endfunction

endpackage

// File: rtl/tempsense_result_tx_uart_tx_8n1.sv
// Single-byte 8N1 serialiser, LSB first, with a registered line output.
// A load during the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_8n1
  import tempsense_result_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [1:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done    = 1'b0;
    bit_end = (div_q == DivW'(CLKS_PER_BIT - 1));

    if (state_q != StIdle) begin
      div_d = bit_end ? '0 : div_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StStart;
          shreg_d = data;
          tx_d    = StartBit;
          div_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'(DataBits - 1)) begin
            state_d = StStop;
            tx_d    = StopBit;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          done = 1'b1;
          if (load) begin
            state_d = StStart;
            shreg_d = data;
            tx_d    = StartBit;
          end else begin
            state_d = StIdle;
            tx_d    = StopBit;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = StopBit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= StopBit;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

endmodule

// File: rtl/tempsense_result_tx.sv
// Temperature-result consumer: boxcar average, min/max tracking and a two-byte
// UART packet {raw, average} per measurement, with a sticky overrun flag.
module tempsense_result_tx
  import tempsense_result_tx_pkg::*;
#(
  parameter int unsigned N_RES        = 6,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_RES-1:0] i_res,
  input  logic             i_res_valid,
  input  logic             i_clr_minmax,
  output logic [N_RES-1:0] o_avg,
  output logic [N_RES-1:0] o_min,
  output logic [N_RES-1:0] o_max,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = N_RES + AVG_LOG2;

  logic [N_RES-1:0] win_q [Depth];
  logic [N_RES-1:0] win_d [Depth];
  logic [SumW-1:0]  sum_q, sum_d;
  logic             filled_q, filled_d;
  logic [N_RES-1:0] avg_q, avg_d;
  logic [N_RES-1:0] min_q, min_d;
  logic [N_RES-1:0] max_q, max_d;
  logic             ovr_q, ovr_d;
  logic             sel_q, sel_d;
  logic [7:0]       byte_b_q, byte_b_d;

  logic             accept;
  logic             tx_load;
  logic [7:0]       tx_data;
  logic             tx_line;
  logic             tx_busy;
  logic             tx_done;

  // Moving average: the first sample after reset fills the whole window so the
  // average starts at the sample value instead of ramping up from zero.
  always_comb begin
    win_d    = win_q;
    sum_d    = sum_q;
    filled_d = filled_q;
    avg_d    = avg_q;
    if (i_res_valid) begin
      if (!filled_q) begin
        for (int i = 0; i < Depth; i++) begin
          win_d[i] = i_res;
        end
        sum_d    = SumW'(i_res) << AVG_LOG2;
        filled_d = 1'b1;
      end else begin
        sum_d = sum_q - SumW'(win_q[Depth-1]) + SumW'(i_res);
        for (int i = Depth - 1; i > 0; i--) begin
          win_d[i] = win_q[i-1];
        end
        win_d[0] = i_res;
      end
      avg_d = N_RES'(sum_d >> AVG_LOG2);
    end
  end

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (i_res_valid && i_clr_minmax) begin
      min_d = i_res;
      max_d = i_res;
    end else if (i_clr_minmax) begin
      min_d = '1;
      max_d = '0;
    end else if (i_res_valid) begin
      min_d = (i_res < min_q) ? i_res : min_q;
      max_d = (i_res > max_q) ? i_res : max_q;
    end
  end

  // Packet sequencing: byte A is loaded on acceptance, byte B on the done pulse
  // that ends byte A, so the two frames run back to back.
  always_comb begin
    accept   = i_res_valid && !tx_busy;
    ovr_d    = ovr_q || (i_res_valid && tx_busy);
    sel_d    = sel_q;
    byte_b_d = byte_b_q;
    tx_load  = 1'b0;
    tx_data  = byte_b_q;
    if (accept) begin
      tx_load  = 1'b1;
      tx_data  = pack_byte(MarkA, 7'(i_res));
      byte_b_d = pack_byte(MarkB, 7'(avg_d));
      sel_d    = MarkA;
    end else if (tx_done && (sel_q == MarkA)) begin
      tx_load = 1'b1;
      tx_data = byte_b_q;
      sel_d   = MarkB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        win_q[i] <= '0;
      end
      sum_q    <= '0;
      filled_q <= 1'b0;
      avg_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
      ovr_q    <= 1'b0;
      sel_q    <= MarkB;
      byte_b_q <= '0;
    end else begin
      win_q    <= win_d;
      sum_q    <= sum_d;
      filled_q <= filled_d;
      avg_q    <= avg_d;
      min_q    <= min_d;
      max_q    <= max_d;
      ovr_q    <= ovr_d;
      sel_q    <= sel_d;
      byte_b_q <= byte_b_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .reset(reset),
    .data (tx_data),
    .load (tx_load),
    .tx   (tx_line),
    .busy (tx_busy),
    .done (tx_done)
  );

  assign o_avg     = avg_q;
  assign o_min     = min_q;
  assign o_max     = max_q;
  assign o_tx      = tx_line;
  assign o_busy    = tx_busy;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_tempsense_result_tx.sv
// Randomised scoreboard bench: a driver updates a behavioural model and queues
// expected packets; a monitor decodes the serial line and checks each frame.
module tb_tempsense_result_tx;

  localparam int CPB   = 3;
  localparam int NR    = 6;
  localparam int AL    = 2;
  localparam int DEPTH = 1 << AL;
  localparam int G     = 20 * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] i_res = '0;
  logic          i_res_valid = 1'b0;
  logic          i_clr_minmax = 1'b0;
  logic [NR-1:0] o_avg, o_min, o_max;
  logic          o_tx, o_busy, o_overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tempsense_result_tx #(
    .N_RES       (NR),
    .AVG_LOG2    (AL),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_res       (i_res),
    .i_res_valid (i_res_valid),
    .i_clr_minmax(i_clr_minmax),
    .o_avg       (o_avg),
    .o_min       (o_min),
    .o_max       (o_max),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    time        t;
  } pkt_t;

  pkt_t exp_q[$];
  int   hist[$];
  int   m_avg, m_min, m_max;
  bit   m_ovr;
  time  busy_end;
  bit   mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_avg    = 0;
    m_min    = (1 << NR) - 1;
    m_max    = 0;
    m_ovr    = 1'b0;
    busy_end = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_avg"}, 32'(o_avg), 32'(m_avg));
    check({tag, "_min"}, 32'(o_min), 32'(m_min));
    check({tag, "_max"}, 32'(o_max), 32'(m_max));
    check({tag, "_overrun"}, 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset_tx", 32'(o_tx), 32'd1);
    check("reset_busy", 32'(o_busy), 32'd0);
    check_regs("reset");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clock edge of stimulus; the model applies the rules at that edge.
  task automatic issue(input bit v, input int val, input bit clr);
    time t;
    int  sum;
    i_res        = NR'(val);
    i_res_valid  = v;
    i_clr_minmax = clr;
    @(posedge clk);
    t = $time;
    if (v) begin
      if (hist.size() == 0) begin
        repeat (DEPTH) hist.push_back(val);
      end else begin
        void'(hist.pop_front());
        hist.push_back(val);
      end
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      m_avg = sum / DEPTH;
      if (clr) begin
        m_min = val;
        m_max = val;
      end else begin
        if (val < m_min) m_min = val;
        if (val > m_max) m_max = val;
      end
      if (t >= busy_end) begin
        exp_q.push_back('{a: 8'h80 | 8'(val), b: 8'(m_avg), t: t + 5});
        busy_end = t + (G + 1) * 10;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (clr) begin
      m_min = (1 << NR) - 1;
      m_max = 0;
    end
    #1;
    i_res_valid  = 1'b0;
    i_clr_minmax = 1'b0;
    check_regs(v ? "valid" : "clr");
  endtask

  // Monitor: decode each 20-bit packet, every bit held for CPB cycles.
  initial begin
    pkt_t       e;
    bit         have;
    bit         hold_ok, busy_ok, aborted;
    logic [19:0] got, want;
    forever begin
      @(negedge clk);
      if (!reset && o_tx === 1'b0) begin
        mon_active = 1'b1;
        have = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got a start bit expected none at %0t", $time);
        end else begin
          e    = exp_q.pop_front();
          have = 1'b1;
          check("frame_start_time", 32'($time), 32'(e.t));
        end
        got     = '0;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 20 && !aborted; k++) begin
          for (int j = 0; j < CPB && !aborted; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (reset) begin
              aborted = 1'b1;
            end else begin
              if (j == 0) got[k] = o_tx;
              else if (o_tx !== got[k]) hold_ok = 1'b0;
              if (o_busy !== 1'b1) busy_ok = 1'b0;
            end
          end
        end
        if (!aborted && have) begin
          want = {1'b1, e.b, 1'b0, 1'b1, e.a, 1'b0};
          check("frame_bits", 32'(got), 32'(want));
          check("frame_bit_hold", 32'(hold_ok), 32'd1);
          check("frame_busy", 32'(busy_ok), 32'd1);
          @(negedge clk);
          if (!reset) begin
            check("busy_after_frame", 32'(o_busy), 32'd0);
            check("tx_idle_after_frame", 32'(o_tx), 32'd1);
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, val, clr, gap;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("init_tx", 32'(o_tx), 32'd1);
    check("init_busy", 32'(o_busy), 32'd0);
    check_regs("init");

    // Sequence 20, 24, 10, 30; the first gap is the earliest accepted spacing.
    issue(1, 20, 0);
    idle(G);
    issue(1, 24, 0);
    idle(G + 5);
    issue(1, 10, 0);
    idle(G);
    issue(1, 30, 0);
    idle(G + 2);
    issue(0, 0, 1);
    idle(G);
    issue(1, 33, 1);
    idle(G + 1);

    // Valid during the final stop-bit cycle is an overrun.
    do_reset();
    issue(1, 20, 0);
    idle(G - 1);
    issue(1, 24, 0);
    idle(G + 2);
    issue(1, 5, 0);
    idle(G + 1);

    // Valid five cycles into a packet.
    do_reset();
    issue(1, 20, 0);
    idle(4);
    issue(1, 24, 0);
    idle(G + 2);

    // Reset while byte B data bits are on the line.
    do_reset();
    issue(1, 50, 0);
    idle(13 * CPB);
    do_reset();
    issue(1, 7, 0);
    idle(G + 1);

    for (int n = 0; n < 60; n++) begin
      val = $urandom_range(0, (1 << NR) - 1);
      clr = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 7) != 0);
      issue(v[0], val, clr[0]);
      gap = $urandom_range(0, 22 * CPB);
      idle(gap);
      if (m_ovr && $urandom_range(0, 1) == 1) do_reset();
    end

    idle(4);
    for (int i = 0; i < 100 * CPB && (exp_q.size() != 0 || mon_active); i++) begin
      @(posedge clk);
    end
    check("drain_pending", 32'(exp_q.size()) + 32'(mon_active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tempsense_result_tx.md
# tempsense_result_tx

Downstream consumer of the temperature-sensor result. It takes each raw N_RES-bit measurement and its one-cycle valid strobe from the sensor controller. It keeps a boxcar moving average and min/max trackers. It serialises every result as a two-byte 8N1 UART packet on a single output pin, so the chip can be logged without reading the 7-segment display.

## Interface
Parameters:
- N_RES, 6, result width; legal range 1..7.
- AVG_LOG2, 2, log2 of the averaging window depth; legal range 0..3.
- CLKS_PER_BIT, 1, clk cycles per UART bit; must be ≥1. Baud rate = f_clk / CLKS_PER_BIT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_res  in  N_RES  raw result; sampled only when i_res_valid=1.
- i_res_valid  in  1  one-cycle strobe; one per measurement.
- i_clr_minmax  in  1  re-initialises the min/max trackers.
- o_avg  out  N_RES  moving average (registered).
- o_min  out  N_RES  minimum since reset/clear.
- o_max  out  N_RES  maximum since reset/clear.
- o_tx  out  1  UART line; idles high.
- o_busy  out  1  packet in flight.
- o_overrun  out  1  sticky flag: a packet was dropped.

## Operation
- Window: 2^AVG_LOG2-entry shift register plus running sum of width N_RES+AVG_LOG2.
- First valid after reset: preload every window entry with the sample, and set sum = sample << AVG_LOG2.
- Later valids: sum_next = sum − oldest + new, then shift the window.
- o_avg = sum >> AVG_LOG2, truncating. It includes the current sample.
- Min/max:
  - Reset values: o_min = all-ones, o_max = 0.
  - On valid: o_min = min(o_min, i_res), o_max = max(o_max, i_res).
  - i_clr_minmax alone reloads the reset values.
  - i_clr_minmax together with a valid reloads both trackers with i_res.
- Packet contents:
  - byte A = {1'b1, zero pad, raw}.
  - byte B = {1'b0, zero pad, new avg}.
  - Bit 7 marks the byte order.
- Packet format: each byte is 8N1, LSB first (start 0, 8 data bits, stop 1). Byte A is sent first and byte B follows back to back, for 20 bits total.
- TX state machine:
  - States: IDLE → START → DATA → STOP.
  - DATA counts 8 bits.
  - After the first STOP, go to START with byte-select = B. After the second STOP, go to IDLE.
  - A bit counter and a divider counter run modulo CLKS_PER_BIT.
- Valid while busy: averaging and min/max still update. The packet is dropped and o_overrun is set; it stays set until reset.
- Valid while IDLE latches both packet bytes at that edge.
- Reset mid-packet: the line is released immediately. Every output returns to its reset value: o_tx=1, o_busy=0, o_overrun=0, o_avg=0, o_min=all-ones, o_max=0. The window is marked empty.

## Timing
- Valid at edge N: o_avg, o_min and o_max show the new values from cycle N+1.
- Start bit of byte A drives o_tx from cycle N+1, together with o_busy=1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- o_busy falls on the cycle after the last stop bit ends. Packet occupancy is 20·CLKS_PER_BIT cycles.
- A valid arriving in the same cycle that o_busy falls (state already IDLE) is accepted.
- A valid arriving during the final stop-bit cycle counts as overrun.
- o_tx is registered, glitch-free.

## Structure
- Shared package holds:
  - TX state encoding (IDLE/START/DATA/STOP).
  - Byte marker constants: MARK_A=1, MARK_B=0.
  - UART frame constants: start bit, stop bit, 8 data bits.
- One sub-module, uart_tx_8n1 (parameter CLKS_PER_BIT):
  - Inputs: 8-bit byte, load strobe.
  - Outputs: tx, busy, done.
  - Instantiated once. The top sequences bytes A/B and owns averaging, min/max and overrun.

## Test plan
- Reset, then valid with i_res=20 (CLKS_PER_BIT=1) → o_avg=20, min=max=20. o_tx sends 0x94 then 0x14 starting the next cycle, LSB first. o_busy lasts 20 cycles.
- Valids 20, 24, 10, 30, with each spaced past packet end → o_avg sequence 20, 21, 18, 21; o_min=10, o_max=30; o_overrun=0.
- Valid 24 issued 5 cycles after valid 20 → o_overrun=1 and stays set. No second packet is sent. o_avg=21 and o_max=24 still update.
- i_clr_minmax alone → min=63, max=0. i_clr_minmax together with valid 33 → min=max=33.
- CLKS_PER_BIT=3: each bit is held 3 cycles and the packet takes 60 cycles. A valid in the cycle o_busy drops is accepted.
- Reset asserted during DATA of byte B → next cycle o_tx=1, o_busy=0, all registers at reset values. The next valid 7 preloads the window, so o_avg=7.
